period_meter: RTL and testbench

Measures the period of a slow external digital signal (e.g. a `divM` output, an external tick or a sensor pulse) in system-clock cycles. It is the receiving counterpart of the clock divider: the divider turns a count into a frequency, and this block turns a frequency back into a count. It sits between any asynchronous pulse source and the display/font logic that shows the measured value.

---
 rtl/sync_rise.sv | 33 +++
 rtl/period_meter.sv | 102 ++++++++++
 tb/tb_period_meter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sync_rise.sv
// rtl/sync_rise.sv - three-flop synchronizer with a one-cycle rising-edge strobe
module sync_rise (
    input  logic clk_in,
    input  logic rst,
    input  logic sig_in,
    output logic rise
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = sig_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Reset to 1 so an input already high at reset release is not seen as a rise.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures rising-edge-to-rising-edge period of an async input in clk_in cycles
module period_meter #(
    parameter int MAX_PERIOD = 12_000_000
) (
    input  logic                                clk_in,
    input  logic                                rst,
    input  logic                                sig_in,
    output logic [$clog2(MAX_PERIOD+1)-1:0]     period,
    output logic                                valid,
    output logic                                locked,
    output logic                                timeout
);

    localparam int W = $clog2(MAX_PERIOD + 1);
    localparam logic [W-1:0] CNT_MAX = W'(MAX_PERIOD);
    localparam logic [W-1:0] CNT_ONE = W'(1);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    logic rise;

    sync_rise u_sync_rise (
        .clk_in (clk_in),
        .rst    (rst),
        .sig_in (sig_in),
        .rise   (rise)
    );

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   period_q, period_d;
    logic           valid_q, valid_d;
    logic           locked_q, locked_d;
    logic           timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // First edge only arms the meter; there is nothing to measure yet.
                if (rise) begin
                    cnt_d   = CNT_ONE;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                // A rise coinciding with the limit still counts as a valid period.
                if (rise) begin
                    period_d  = cnt_q;
                    valid_d   = 1'b1;
                    locked_d  = 1'b1;
                    timeout_d = 1'b0;
                    cnt_d     = CNT_ONE;
                end else if (cnt_q == CNT_MAX) begin
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign period  = period_q;
    assign valid   = valid_q;
    assign locked  = locked_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - scoreboard bench for period_meter with MAX_PERIOD=100
module tb_period_meter;

    localparam int MAXP = 100;
    localparam int PW   = $clog2(MAXP + 1);

    logic          clk_in = 1'b0;
    logic          rst    = 1'b1;
    logic          sig_in = 1'b0;
    logic [PW-1:0] period;
    logic          valid;
    logic          locked;
    logic          timeout;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    period_meter #(.MAX_PERIOD(MAXP)) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .sig_in  (sig_in),
        .period  (period),
        .valid   (valid),
        .locked  (locked),
        .timeout (timeout)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // One rise, high for hi cycles, next rise total cycles later; exp=0 means no valid expected.
    task automatic pulse(input int total, input int hi, input int exp);
        sig_in = 1'b1;
        if (exp != 0) exp_q.push_back(exp);
        tick(hi);
        sig_in = 1'b0;
        tick(total - hi);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk_in);
                if (!rst && valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 1, 0);
                    end else begin
                        check("period", int'(period), exp_q.pop_front());
                        check("locked_on_valid", int'(locked), 1);
                    end
                end
            end
        join_none

        tick(3);
        check("reset_period", int'(period), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_locked", int'(locked), 0);
        check("reset_timeout", int'(timeout), 0);
        rst = 1'b0;
        tick(5);

        // Steady 20-cycle square wave.
        pulse(20, 10, 0);
        check("locked_after_arm", int'(locked), 0);
        for (int i = 0; i < 5; i++) pulse(20, 10, 20);
        check("locked_steady", int'(locked), 1);

        // Timeout: last accepted rise, then low for 150 cycles.
        sig_in = 1'b1;
        exp_q.push_back(20);
        tick(5);
        sig_in = 1'b0;
        tick(97);
        check("timeout_before_limit", int'(timeout), 0);
        check("locked_before_limit", int'(locked), 1);
        tick(1);
        check("timeout_at_limit", int'(timeout), 1);
        check("locked_at_limit", int'(locked), 0);
        check("period_kept", int'(period), 20);
        tick(52);
        pulse(20, 10, 0);
        check("timeout_after_rearm", int'(timeout), 1);
        pulse(20, 10, 20);
        check("timeout_cleared", int'(timeout), 0);
        check("relocked", int'(locked), 1);

        // Minimum period: toggle every cycle.
        pulse(2, 1, 20);
        for (int i = 0; i < 8; i++) pulse(2, 1, 2);

        // Boundary: rises exactly MAXP apart.
        pulse(100, 50, 2);
        pulse(100, 50, 100);
        check("boundary_no_timeout", int'(timeout), 0);
        pulse(100, 50, 100);
        check("boundary_no_timeout2", int'(timeout), 0);
        check("boundary_period", int'(period), 100);
        check("queue_empty_1", exp_q.size(), 0);

        // High at reset.
        rst    = 1'b1;
        sig_in = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(10);
        sig_in = 1'b0;
        tick(20);
        pulse(25, 10, 0);
        check("hi_reset_no_lock", int'(locked), 0);
        pulse(25, 10, 25);
        check("hi_reset_locked", int'(locked), 1);

        // Reset 7 cycles into a 40-cycle period.
        sig_in = 1'b1;
        exp_q.push_back(25);
        tick(7);
        check("queue_empty_2", exp_q.size(), 0);
        rst = 1'b1;
        #1;
        check("midrst_period", int'(period), 0);
        check("midrst_valid", int'(valid), 0);
        check("midrst_locked", int'(locked), 0);
        check("midrst_timeout", int'(timeout), 0);
        tick(2);
        rst = 1'b0;
        tick(13);
        sig_in = 1'b0;
        tick(20);
        pulse(40, 20, 0);
        check("midrst_no_lock", int'(locked), 0);
        pulse(40, 20, 40);
        pulse(40, 20, 40);
        tick(5);
        check("queue_empty_end", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
